// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// It produces the operand forwarding selects for Execute and Decode.
// It produces the stall/flush controls for load-use, branch-operand and
// multi-cycle memory hazards, and counts front-end stall cycles.
module hazard_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    input  logic [4:0]       Rs_E,
    input  logic [4:0]       Rt_E,
    input  logic [4:0]       WriteReg_E,
    input  logic [4:0]       WriteReg_M,
    input  logic [4:0]       WriteReg_W,
    input  logic             RegWrite_E,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic             MemtoReg_E,
    input  logic             MemtoReg_M,
    input  logic             MemWrite_M,
    input  logic             Branch_D,
    input  logic             cnt_clr,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             ForwardA_D,
    output logic             ForwardB_D,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_e;

    // Countdown loaded on entry to WAIT; MEM_LAT is at most 15.
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    mem_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

    logic       mem_access;
    logic       mem_stall;
    logic       lwstall;
    logic       brstall;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       stall_front;

    // Register match that ignores $zero, which is never a real dependency.
    function automatic logic reg_hit(input logic en, input logic [4:0] dst,
                                     input logic [4:0] src);
        return en && (dst != 5'd0) && (dst == src);
    endfunction

    // Memory stage result wins over writeback because it is the younger write.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (reg_hit(RegWrite_M, WriteReg_M, src))
            return 2'b10;
        else if (reg_hit(RegWrite_W, WriteReg_W, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Hazard detection for forwarding, load-use and branch-compare operands.
    always_comb begin
        fwd_a_e    = fwd_sel(Rs_E);
        fwd_b_e    = fwd_sel(Rt_E);
        mem_access = MemtoReg_M || MemWrite_M;
        lwstall    = reg_hit(MemtoReg_E, Rt_E, Rs_D) || reg_hit(MemtoReg_E, Rt_E, Rt_D);
        brstall    = Branch_D &&
                     (reg_hit(RegWrite_E, WriteReg_E, Rs_D) ||
                      reg_hit(RegWrite_E, WriteReg_E, Rt_D) ||
                      reg_hit(MemtoReg_M, WriteReg_M, Rs_D) ||
                      reg_hit(MemtoReg_M, WriteReg_M, Rt_D));
    end

    // Memory-wait sequencer: MEM_LAT stall cycles, then one DONE cycle so the
    // same instruction leaves M instead of re-triggering the wait.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_access && (MEM_LAT > 0)) begin
                    mem_stall = 1'b1;
                    if (MEM_LAT == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; reset forces every control to its inactive value.
    always_comb begin
        stall_front = !rst && (lwstall || brstall || mem_stall);
        ForwardA_E  = rst ? 2'b00 : fwd_a_e;
        ForwardB_E  = rst ? 2'b00 : fwd_b_e;
        ForwardA_D  = !rst && reg_hit(RegWrite_M, WriteReg_M, Rs_D);
        ForwardB_D  = !rst && reg_hit(RegWrite_M, WriteReg_M, Rt_D);
        StallF      = stall_front;
        StallD      = stall_front;
        StallE      = !rst && mem_stall;
        StallM      = !rst && mem_stall;
        // Execute is frozen during a memory wait, so no bubble is injected then.
        FlushE      = !rst && (lwstall || brstall) && !mem_stall;
        FlushW      = !rst && mem_stall;
        mem_busy    = !rst && mem_stall;
    end

    // Saturating stall counter; clear takes priority over increment.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (cnt_clr)
            stall_cycles_d = '0;
        else if (stall_front && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    // State, countdown and performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instance A (MEM_LAT=2, 8-bit counter) and
// instance B (MEM_LAT=4) share stimulus but have separate resets.
module tb_hazard_ctrl;

    logic clk;
    logic rst_a, rst_b;
    logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M, MemWrite_M;
    logic Branch_D, cnt_clr;

    logic [1:0] a_FwdA_E, a_FwdB_E, b_FwdA_E, b_FwdB_E;
    logic a_FwdA_D, a_FwdB_D, b_FwdA_D, b_FwdB_D;
    logic a_StallF, a_StallD, a_StallE, a_StallM, a_FlushE, a_FlushW, a_busy;
    logic b_StallF, b_StallD, b_StallE, b_StallM, b_FlushE, b_FlushW, b_busy;
    logic [7:0]  a_cycles;
    logic [15:0] b_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(.MEM_LAT(2), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M), .MemWrite_M(MemWrite_M),
        .Branch_D(Branch_D), .cnt_clr(cnt_clr),
        .ForwardA_E(a_FwdA_E), .ForwardB_E(a_FwdB_E),
        .ForwardA_D(a_FwdA_D), .ForwardB_D(a_FwdB_D),
        .StallF(a_StallF), .StallD(a_StallD), .StallE(a_StallE), .StallM(a_StallM),
        .FlushE(a_FlushE), .FlushW(a_FlushW), .mem_busy(a_busy),
        .stall_cycles(a_cycles)
    );

    hazard_ctrl #(.MEM_LAT(4), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M), .MemWrite_M(MemWrite_M),
        .Branch_D(Branch_D), .cnt_clr(cnt_clr),
        .ForwardA_E(b_FwdA_E), .ForwardB_E(b_FwdB_E),
        .ForwardA_D(b_FwdA_D), .ForwardB_D(b_FwdB_D),
        .StallF(b_StallF), .StallD(b_StallD), .StallE(b_StallE), .StallM(b_StallM),
        .FlushE(b_FlushE), .FlushW(b_FlushW), .mem_busy(b_busy),
        .stall_cycles(b_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        Rs_D = 0; Rt_D = 0; Rs_E = 0; Rt_E = 0;
        WriteReg_E = 0; WriteReg_M = 0; WriteReg_W = 0;
        RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
        MemtoReg_E = 0; MemtoReg_M = 0; MemWrite_M = 0;
        Branch_D = 0; cnt_clr = 0;
    endtask

    // Leaves time 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic pat [6];
        logic patb [5];
        pat  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        patb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset with hazards present: everything must be inactive.
        rst_a = 1; rst_b = 1;
        clear_inputs();
        MemtoReg_M = 1; MemtoReg_E = 1; Rt_E = 8; Rs_D = 8;
        RegWrite_M = 1; WriteReg_M = 5; Rs_E = 5;
        #1;
        check("rst_stallF", a_StallF, 0);
        check("rst_flushE", a_FlushE, 0);
        check("rst_busy", a_busy, 0);
        check("rst_fwdA_E", a_FwdA_E, 0);
        check("rst_cycles", a_cycles, 0);
        step(); step();
        clear_inputs();
        rst_a = 0; rst_b = 0;
        #1;

        // Forwarding priority.
        RegWrite_M = 1; WriteReg_M = 5; RegWrite_W = 1; WriteReg_W = 5; Rs_E = 5;
        #1 check("fwdA_M_prio", a_FwdA_E, 2'b10);
        RegWrite_M = 0;
        #1 check("fwdA_W", a_FwdA_E, 2'b01);
        RegWrite_M = 1; Rt_E = 5;
        #1 check("fwdB_M", a_FwdB_E, 2'b10);
        Rs_E = 0; Rt_E = 0; WriteReg_M = 0; WriteReg_W = 0;
        #1 check("fwdA_r0", a_FwdA_E, 2'b00);
        check("fwdB_r0", a_FwdB_E, 2'b00);
        WriteReg_M = 7; Rs_D = 7; Rt_D = 7;
        #1 check("fwdA_D", a_FwdA_D, 1);
        check("fwdB_D", a_FwdB_D, 1);
        RegWrite_M = 0;
        #1 check("fwdA_D_off", a_FwdA_D, 0);
        clear_inputs();

        // Load-use stall.
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        #1 check("clr_cycles", a_cycles, 0);
        MemtoReg_E = 1; Rt_E = 8; Rs_D = 8;
        #1 check("lw_stallF", a_StallF, 1);
        check("lw_stallD", a_StallD, 1);
        check("lw_flushE", a_FlushE, 1);
        check("lw_stallE", a_StallE, 0);
        step();
        MemtoReg_E = 0;
        #1 check("lw_after_stallF", a_StallF, 0);
        check("lw_after_flushE", a_FlushE, 0);
        check("lw_cycles", a_cycles, 1);
        MemtoReg_E = 1; Rt_E = 0; Rs_D = 0;
        #1 check("lw_r0", a_StallF, 0);
        clear_inputs();

        // Branch operand hazard, then resolved by forwarding from M.
        Branch_D = 1; Rs_D = 3; RegWrite_E = 1; WriteReg_E = 3;
        #1 check("br_stallD", a_StallD, 1);
        check("br_flushE", a_FlushE, 1);
        check("br_stallE", a_StallE, 0);
        RegWrite_E = 0; WriteReg_E = 0; RegWrite_M = 1; WriteReg_M = 3;
        #1 check("br_fwd_stallD", a_StallD, 0);
        check("br_fwdA_D", a_FwdA_D, 1);
        clear_inputs();

        // Memory wait, load held in M: 2 stalls, DONE, next instruction.
        step();
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        MemtoReg_M = 1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ld_stallM_%0d", i), a_StallM, pat[i]);
            check($sformatf("ld_stallF_%0d", i), a_StallF, pat[i]);
            check($sformatf("ld_stallE_%0d", i), a_StallE, pat[i]);
            check($sformatf("ld_flushW_%0d", i), a_FlushW, pat[i]);
            if (i == 1) begin
                MemtoReg_E = 1; Rt_E = 8; Rs_D = 8;
                #1 check("memwait_no_flushE", a_FlushE, 0);
                check("memwait_lw_stallD", a_StallD, 1);
                MemtoReg_E = 0; Rt_E = 0; Rs_D = 0;
                #1;
            end
            step();
        end
        MemtoReg_M = 0;
        #1 check("ld_cycles", a_cycles, 4);
        check("ld_idle", a_busy, 0);

        // Back-to-back stores.
        MemWrite_M = 1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("st_busy_%0d", i), a_busy, pat[i]);
            check($sformatf("st_stallD_%0d", i), a_StallD, pat[i]);
            step();
        end
        MemWrite_M = 0;
        #1 check("st_cycles", a_cycles, 8);

        // Reset in the middle of a MEM_LAT=4 wait.
        clear_inputs();
        repeat (6) step();
        MemtoReg_M = 1;
        #1 check("b_wait_c1", b_busy, 1);
        step();
        check("b_wait_c2", b_busy, 1);
        RegWrite_M = 1; WriteReg_M = 5; Rs_E = 5;
        rst_b = 1;
        #1 check("b_rst_busy", b_busy, 0);
        check("b_rst_stallF", b_StallF, 0);
        check("b_rst_stallM", b_StallM, 0);
        check("b_rst_fwdA_E", b_FwdA_E, 2'b00);
        check("b_rst_cycles", b_cycles, 0);
        step(); step();
        rst_b = 0;
        #1 check("b_post_fwdA_E", b_FwdA_E, 2'b10);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("b_restart_%0d", i), b_StallE, patb[i]);
            step();
        end
        check("b_restart_cycles", b_cycles, 4);
        clear_inputs();
        repeat (4) step();

        // Counter saturation and clear during a stall.
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        MemtoReg_E = 1; Rt_E = 8; Rs_D = 8;
        #1;
        repeat (259) step();
        check("cnt_sat", a_cycles, 8'hFF);
        step();
        check("cnt_sat_hold", a_cycles, 8'hFF);
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        check("cnt_clr_in_stall", a_cycles, 0);
        step();
        check("cnt_resume", a_cycles, 1);
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
